serial_frame_rx: RTL and testbench

//  Receive side of the lab single-wire serial link: samples the idle-high line rx_d, detects

---
 rtl/sfrx_pkg.sv | 13 +
 rtl/sfrx_bit_timer.sv | 37 +++
 rtl/serial_frame_rx.sv | 211 +++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sfrx_pkg.sv
// Shared constants for the serial frame receiver: FSM state encodings and line levels.
package sfrx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sfrx_bit_timer.sv
// Loadable down-counter for bit timing. tick is high while the count sits at zero; the
// counter saturates there instead of wrapping, so a missed reload never aliases a bit.
module sfrx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    localparam int unsigned CntW        = $clog2(CLKS_PER_BIT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    output logic            tick
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload on request, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Single-wire serial frame receiver: idle-high line, start bit, DATA_W bits LSB first,
// optional even parity bit (build with SFRX_PARITY_EN), stop bit. Received words are
// offered on a valid/ready port; errors are reported as one-cycle pulses.
module serial_frame_rx
    import sfrx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_d,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
`ifdef SFRX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned TmrW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_W + 1);
    localparam logic [TmrW-1:0] FullLoad = TmrW'(CLKS_PER_BIT - 1);
    localparam logic [TmrW-1:0] HalfLoad = TmrW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]        sync_q, sync_d;
    logic [1:0]        prime_q, prime_d;
    logic              armed_q, armed_d;
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              par_bad_q, par_bad_d;
    logic              tmr_load;
    logic [TmrW-1:0]   tmr_val;
    logic              tick;
    logic              rx_s;

    assign rx_s = sync_q[1];

    sfrx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tick    (tick)
    );

    // Synchronizer shift and arming: the sync flops reset to idle, so the line only counts
    // as observed idle once real samples have propagated through both stages.
    always_comb begin
        sync_d  = {sync_q[0], rx_d};
        prime_d = {prime_q[0], 1'b1};
        armed_d = armed_q | (prime_q[1] & (rx_s == LINE_IDLE));
    end

    // Frame FSM: start detect, mid-bit sampling, parity and stop checks.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        par_bad_d   = par_bad_q;
        tmr_load    = 1'b0;
        tmr_val     = FullLoad;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && rx_s != LINE_IDLE) begin
                    state_d   = ST_START;
                    tmr_load  = 1'b1;
                    tmr_val   = HalfLoad;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    tmr_load = 1'b1;
                    idx_d    = '0;
                    state_d  = (rx_s != LINE_IDLE) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tmr_load = 1'b1;
                    // Shift in from the top: after DATA_W samples bit 0 holds the first bit.
                    shift_d  = {rx_s, shift_q[DATA_W-1:1]};
                    idx_d    = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(DATA_W - 1)) begin
`ifdef SFRX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef SFRX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tmr_load  = 1'b1;
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    tmr_load = 1'b1;
                    if (rx_s == LINE_IDLE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s == LINE_IDLE) begin
                    tmr_load = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load a completed word unless the previous one is still unaccepted.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = 1'b0;
        if (done_q) begin
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end
        end
    end

    // All state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= {2{LINE_IDLE}};
            prime_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_bad_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prime_q     <= prime_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            par_bad_q   <= par_bad_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef SFRX_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Parity error pulse is concurrent with the word load (or the overrun drop).
    always_comb begin
        parity_err_d = done_q & par_bad_q;
    end

    // Parity error pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (DATA_W=8, CLKS_PER_BIT=4). Optional parity build
// with SFRX_PARITY_EN.
module tb_serial_frame_rx;
    import sfrx_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_d = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       perr_sig;

    int n_checks = 0;
    int n_pass = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_frame_rx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_d      (rx_d),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SFRX_PARITY_EN
        ,
        .parity_err(perr_sig)
`endif
    );

`ifndef SFRX_PARITY_EN
    assign perr_sig = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_d = b;
        repeat (CPB) step();
    endtask

    // Start, 8 data bits LSB first, optional parity, stop, then an idle tail.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SFRX_PARITY_EN
        send_bit(par_b);
`else
        if (par_b === 1'bx) $display("unexpected parity arg");
`endif
        send_bit(stop_b);
        rx_d = 1'b1;
        repeat (2 * CPB) step();
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            step();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: counts pulses and pops the scoreboard on every handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (out_valid) valid_cycles++;
                if (frame_err) ferr_cnt++;
                if (overrun) ovr_cnt++;
                if (perr_sig) perr_cnt++;
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_word: got %0h, expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data === e.data && perr_sig === e.perr) n_pass++;
                        else $display("FAIL word: got %0h perr %0b, expected %0h perr %0b",
                                      out_data, perr_sig, e.data, e.perr);
                    end
                end
            end
        end
    endtask

    initial begin
        int v0, f0, o0;
        fork
            monitor();
        join_none

        // Reset held low with an idle line.
        repeat (3) step();
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", dut.state_q, ST_IDLE);
        reset = 1'b1;
        repeat (100) step();
        check("idle_no_valid", valid_cycles, 0);

        // Clean frame 0xA5.
        v0 = valid_cycles;
        f0 = ferr_cnt;
        push(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_drain("drain_a5");
        repeat (4) step();
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_no_frame_err", ferr_cnt - f0, 0);

        // One-cycle glitch on the idle line.
        v0 = valid_cycles;
        rx_d = 1'b0;
        step();
        rx_d = 1'b1;
        repeat (20) step();
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_state", dut.state_q, ST_IDLE);

        // Bad stop bit, then a good frame.
        v0 = valid_cycles;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (4) step();
        check("3c_frame_err", ferr_cnt - f0, 1);
        check("3c_no_valid", valid_cycles - v0, 0);
        check("3c_state", dut.state_q, ST_IDLE);
        push(8'h81, 1'b0);
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_drain("drain_81");

        // Consumer stalled: second word is dropped with an overrun pulse.
        out_ready = 1'b0;
        o0 = ovr_cnt;
        push(8'h11, 1'b0);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_hold_data", out_data, 8'h11);
        check("ovr_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("drain_11");
        step();
        check("ovr_valid_drop", out_valid, 0);

`ifdef SFRX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, 1 is right.
        push(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("drain_07_bad");
        push(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain("drain_07_good");
        check("parity_err_count", perr_cnt, 1);
`else
        check("no_parity_err", perr_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
